tt_um_rps_match_ctrl: RTL and testbench
=======================================

# tt_um_rps_match_ctrl

Best-of-N match controller for the stone-paper-scissors game. It synchronizes and edge-detects both players' commit buttons, latches each player's move, and sequences rounds through a judge sub-module. It keeps per-player scores, holds each round result on the display, and declares a match winner. It is the top-level Tiny Tapeout user module, replacing the single-shot judge as the chip-level entry point.

## Interface
Parameters:
- WIN_TARGET, 3, rounds needed to win the match (legal range 1..15; 3 = best of 5).
- HOLD_CYCLES, 16, number of cycles a round result is shown (legal range ≥1).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  enable. When low, all state holds except the input synchronizers.
- ui_in  input  8  player inputs:
  - [1:0] P1 move, [3:2] P2 move.
  - [4] P1 commit, [5] P2 commit, [6] start.
  - [7] unused.
- uo_out  output  8  registered ASCII status code.
- uio_in  input  8  unused.
- uio_out  output  8  registered scores: [3:0] P1 score, [7:4] P2 score.
- uio_oe  output  8  constant 8'hFF.

## Operation
- Moves: 0 = stone, 1 = paper, 2 = scissors, 3 = invalid.
- Synchronization:
  - ui_in[6:0] passes through a two-flop synchronizer that runs regardless of ena.
  - Commit and start are rising-edge detected against a prev register, which also updates regardless of ena.
  - An edge pulse is acted on only when ena = 1. Edges that occur while ena = 0 are lost.
- FSM states: IDLE, COLLECT, JUDGE, SHOW, DONE.
- IDLE: uo_out = 0. A start edge goes to COLLECT, clears both scores, and clears both got flags.
- COLLECT: uo_out = 46 ('.'), or 63 ('?') while the invalid flag is set.
  - A Px commit edge with a valid synchronized move latches the move and sets got_x. It also clears the invalid flag.
  - A Px commit edge with move 3 is rejected: got_x stays clear and the invalid flag is set.
  - A commit edge while got_x is already set is ignored; the first move stands.
  - When both got flags are set, go to JUDGE.
- JUDGE (exactly 1 cycle):
  - rps_judge compares the latched moves: stone beats scissors, paper beats stone, scissors beats paper.
  - The winner's score increments; a tie changes neither score.
  - The hold counter loads HOLD_CYCLES-1. Go to SHOW.
- SHOW: uo_out = 49 ('1'), 50 ('2') or 84 ('T') for P1 win, P2 win or tie.
  - The counter decrements each cycle.
  - When the counter reaches 0: if either score equals WIN_TARGET, go to DONE. Otherwise clear the got flags and go to COLLECT.
- DONE: uo_out = 65 ('A') if P1 won the match, 66 ('B') if P2 won. Scores hold.
- Start edge in COLLECT, JUDGE, SHOW or DONE: abort the match, clear scores, got flags, invalid flag and counter, then go to COLLECT.
- Commit edges are ignored in IDLE, JUDGE, SHOW and DONE.
- Simultaneous events:
  - Both commits on the same cycle are both latched; JUDGE follows on the next cycle.
  - A start edge coinciding with a commit: start wins and the commit is dropped.
- Score width: 4 bits, with no wrap. Scores cannot exceed WIN_TARGET because the match ends at WIN_TARGET.

## Timing
- Reset values: state = IDLE, uo_out = 0, uio_out = 0, latched moves = 0, all flags = 0, counter = 0, synchronizer flops = 0. uio_oe = 8'hFF at all times.
- Commit latency: commit pin first sampled high at clock edge k → sync2 high after edge k+1 → move latched and got_x set at edge k+2.
- Move bits travel through the same synchronizer as the commit bits, so a move must be stable from edge k-1 through edge k+1.
- Second got flag set at edge n:
  - state = JUDGE during cycle n+1.
  - Scores and result code update at edge n+2, when SHOW is entered.
  - SHOW lasts exactly HOLD_CYCLES cycles.
  - Next state (COLLECT or DONE) and its uo_out appear at edge n+2+HOLD_CYCLES.
- uo_out and uio_out are registered and change only on clk edges or on reset.
- Reset assertion mid-match immediately returns all outputs to their reset values, regardless of clk.

## Structure
- Package rps_pkg holds:
  - Move encodings: MV_STONE, MV_PAPER, MV_SCISSORS, MV_INVALID.
  - Result enum: RES_TIE, RES_P1, RES_P2.
  - FSM state enum.
  - ASCII constants: 46, 63, 49, 50, 84, 65, 66.
- Sub-module rps_judge, purely combinational:
  - Inputs: two 2-bit valid moves.
  - Output: 2-bit result.
  - It is instantiated once, in the controller.
- Synchronizer and edge detection stay inline in the controller.

## Test plan
1. Reset, then start edge, then P1 commits 0 and P2 commits 2 → after the JUDGE cycle, uo_out = 49 and uio_out = 8'h01 for 16 cycles, then uo_out = 46.
2. P1 move 3 commit → uo_out = 63 and got_1 stays clear. Then P1 move 1 commit → uo_out = 46 and got_1 is set.
3. Same-cycle commits of 1 and 1 → uo_out = 84 for HOLD_CYCLES cycles and scores unchanged at 8'h00.
4. P2 wins three rounds with P1 winning one → uio_out = 8'h31, then uo_out = 66 in DONE. Further commits are ignored and a start edge returns to '.' with scores 8'h00.
5. Repeated P1 commit with a changed move before P2 commits → the first move is used for judging.
6. Start edge during SHOW, ena held low across a commit pulse, and rst_n pulsed mid-SHOW:
   - Start edge during SHOW → match restarts with scores 0.
   - Commit pulse while ena = 0 → dropped.
   - rst_n pulse mid-SHOW → outputs go to 0 asynchronously.

Source files
------------

// File: rtl/rps_pkg.sv
// Shared encodings for the stone-paper-scissors match controller:
// move codes, round results, FSM states and the ASCII status characters.
package rps_pkg;

    localparam logic [1:0] MV_STONE    = 2'd0;
    localparam logic [1:0] MV_PAPER    = 2'd1;
    localparam logic [1:0] MV_SCISSORS = 2'd2;
    localparam logic [1:0] MV_INVALID  = 2'd3;

    typedef enum logic [1:0] {
        RES_TIE = 2'd0,
        RES_P1  = 2'd1,
        RES_P2  = 2'd2
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_JUDGE,
        ST_SHOW,
        ST_DONE
    } state_e;

    localparam logic [7:0] ASCII_DOT   = 8'd46;  // '.'
    localparam logic [7:0] ASCII_QMARK = 8'd63;  // '?'
    localparam logic [7:0] ASCII_ONE   = 8'd49;  // '1'
    localparam logic [7:0] ASCII_TWO   = 8'd50;  // '2'
    localparam logic [7:0] ASCII_TIE   = 8'd84;  // 'T'
    localparam logic [7:0] ASCII_A     = 8'd65;  // 'A'
    localparam logic [7:0] ASCII_B     = 8'd66;  // 'B'

endpackage

// File: rtl/rps_judge.sv
// Combinational round judge: compares two valid moves and reports the winner.
import rps_pkg::*;

module rps_judge (
    input  logic [1:0] mv1,
    input  logic [1:0] mv2,
    output result_e    result
);

    always_comb begin
        result = RES_P2;
        if (mv1 == mv2) begin
            result = RES_TIE;
        end else if ((mv1 == MV_STONE    && mv2 == MV_SCISSORS) ||
                     (mv1 == MV_PAPER    && mv2 == MV_STONE)    ||
                     (mv1 == MV_SCISSORS && mv2 == MV_PAPER)) begin
            result = RES_P1;
        end
    end

endmodule

// File: rtl/tt_um_rps_match_ctrl.sv
// Best-of-N stone-paper-scissors match controller (Tiny Tapeout top level):
// synchronizes the buttons, collects moves, judges rounds and keeps score.
import rps_pkg::*;

module tt_um_rps_match_ctrl #(
    parameter int WIN_TARGET  = 3,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int             CNT_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]     WIN_SCORE = 4'(WIN_TARGET);

    logic [6:0] sync1_q, sync2_q;
    logic [2:0] prev_q;
    logic       unused_in;

    state_e           state_q, state_d;
    result_e          res_q, res_d, judge_res;
    logic [1:0]       mv1_q, mv1_d, mv2_q, mv2_d;
    logic             got1_q, got1_d, got2_q, got2_d, inv_q, inv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       score1_q, score1_d, score2_q, score2_d;
    logic [7:0]       uo_q, uo_d;
    logic             c1_e, c2_e, start_e, rej1, rej2, acc1, acc2;

    assign unused_in = &{1'b0, uio_in, ui_in[7]};
    assign uio_oe    = 8'hFF;
    assign uo_out    = uo_q;
    assign uio_out   = {score2_q, score1_q};

    // Synchronizer and edge history keep running even while ena is low,
    // so edges seen during that time are consumed and lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= ui_in[6:0];
            sync2_q <= sync1_q;
            prev_q  <= sync2_q[6:4];
        end
    end

    assign c1_e    = ena & sync2_q[4] & ~prev_q[0];
    assign c2_e    = ena & sync2_q[5] & ~prev_q[1];
    assign start_e = ena & sync2_q[6] & ~prev_q[2];

    rps_judge u_judge (
        .mv1    (mv1_q),
        .mv2    (mv2_q),
        .result (judge_res)
    );

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        mv1_d    = mv1_q;
        mv2_d    = mv2_q;
        got1_d   = got1_q;
        got2_d   = got2_q;
        inv_d    = inv_q;
        cnt_d    = cnt_q;
        score1_d = score1_q;
        score2_d = score2_q;
        acc1     = c1_e & ~got1_q & (sync2_q[1:0] != MV_INVALID);
        acc2     = c2_e & ~got2_q & (sync2_q[3:2] != MV_INVALID);
        rej1     = c1_e & ~got1_q & (sync2_q[1:0] == MV_INVALID);
        rej2     = c2_e & ~got2_q & (sync2_q[3:2] == MV_INVALID);

        if (start_e) begin
            state_d  = ST_COLLECT;
            score1_d = '0;
            score2_d = '0;
            got1_d   = 1'b0;
            got2_d   = 1'b0;
            inv_d    = 1'b0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (got1_q && got2_q) begin
                        state_d = ST_JUDGE;
                    end else begin
                        if (acc1) begin
                            mv1_d  = sync2_q[1:0];
                            got1_d = 1'b1;
                        end
                        if (acc2) begin
                            mv2_d  = sync2_q[3:2];
                            got2_d = 1'b1;
                        end
                        // A rejection on the same cycle as an acceptance keeps '?' shown.
                        if (rej1 || rej2) inv_d = 1'b1;
                        else if (acc1 || acc2) inv_d = 1'b0;
                    end
                end
                ST_JUDGE: begin
                    res_d = judge_res;
                    if (judge_res == RES_P1) score1_d = score1_q + 4'd1;
                    if (judge_res == RES_P2) score2_d = score2_q + 4'd1;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (cnt_q == '0) begin
                        if (score1_q == WIN_SCORE || score2_q == WIN_SCORE) begin
                            state_d = ST_DONE;
                        end else begin
                            got1_d  = 1'b0;
                            got2_d  = 1'b0;
                            inv_d   = 1'b0;
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end

        // Status code is derived from next-state values so it is registered
        // in step with the state it describes.
        uo_d = 8'd0;
        case (state_d)
            ST_COLLECT: uo_d = inv_d ? ASCII_QMARK : ASCII_DOT;
            ST_JUDGE:   uo_d = ASCII_DOT;
            ST_SHOW:    uo_d = (res_d == RES_P1) ? ASCII_ONE :
                               (res_d == RES_P2) ? ASCII_TWO : ASCII_TIE;
            ST_DONE:    uo_d = (score1_d == WIN_SCORE) ? ASCII_A : ASCII_B;
            default:    uo_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            res_q    <= RES_TIE;
            mv1_q    <= '0;
            mv2_q    <= '0;
            got1_q   <= 1'b0;
            got2_q   <= 1'b0;
            inv_q    <= 1'b0;
            cnt_q    <= '0;
            score1_q <= '0;
            score2_q <= '0;
            uo_q     <= '0;
        end else if (ena) begin
            state_q  <= state_d;
            res_q    <= res_d;
            mv1_q    <= mv1_d;
            mv2_q    <= mv2_d;
            got1_q   <= got1_d;
            got2_q   <= got2_d;
            inv_q    <= inv_d;
            cnt_q    <= cnt_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            uo_q     <= uo_d;
        end
    end

endmodule

// File: tb/tb_tt_um_rps_match_ctrl.sv
// Self-checking bench for tt_um_rps_match_ctrl: table of rounds through a
// full match plus hand-written sequences for invalid moves, aborts, ena and reset.
module tb_tt_um_rps_match_ctrl;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
    } exp_t;

    typedef struct {
        logic [1:0] m1;
        logic [1:0] m2;
        logic [7:0] uo;
        logic [7:0] uio;
        logic [7:0] after;
    } round_t;

    exp_t   sb[$];
    round_t rounds[6];

    always #5 clk = ~clk;

    tt_um_rps_match_ctrl #(.WIN_TARGET(3), .HOLD_CYCLES(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive moves and commit pins, then follow the round through JUDGE and SHOW.
    // Expected SHOW code and scores come from the scoreboard queue.
    task automatic play_round(input string name, input logic [1:0] m1, input logic [1:0] m2,
                              input logic [1:0] cm, input logic [7:0] after);
        exp_t e;
        int   bad;
        @(negedge clk);
        ui_in[1:0] = m1;
        ui_in[3:2] = m2;
        ui_in[5:4] = cm;
        tick(4);
        chk({name, " judge"}, uo_out, 8'd46);
        tick(1);
        if (sb.size() == 0) begin
            chk({name, " scoreboard"}, 0, 1);
            e.uo  = 8'hxx;
            e.uio = 8'hxx;
        end else begin
            e = sb.pop_front();
        end
        chk({name, " result"}, uo_out, e.uo);
        chk({name, " scores"}, uio_out, e.uio);
        ui_in[5:4] = 2'b00;
        bad = 0;
        for (int i = 1; i < HOLD; i++) begin
            tick(1);
            if (uo_out !== e.uo || uio_out !== e.uio) bad++;
        end
        chk({name, " hold"}, bad, 0);
        tick(1);
        chk({name, " after"}, uo_out, after);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        ui_in[6] = 1'b1;
        tick(3);
        ui_in[6] = 1'b0;
        tick(3);
    endtask

    task automatic commit1(input logic [1:0] mv);
        @(negedge clk);
        ui_in[1:0] = mv;
        ui_in[4]   = 1'b1;
        tick(3);
        ui_in[4] = 1'b0;
        tick(3);
    endtask

    initial begin
        rounds[0] = '{2'd1, 2'd1, 8'd84, 8'h00, 8'd46};
        rounds[1] = '{2'd0, 2'd2, 8'd49, 8'h01, 8'd46};
        rounds[2] = '{2'd0, 2'd1, 8'd50, 8'h11, 8'd46};
        rounds[3] = '{2'd2, 2'd0, 8'd50, 8'h21, 8'd46};
        rounds[4] = '{2'd2, 2'd2, 8'd84, 8'h21, 8'd46};
        rounds[5] = '{2'd1, 2'd2, 8'd50, 8'h31, 8'd66};

        // Reset state
        tick(2);
        chk("reset uo", uo_out, 8'd0);
        chk("reset uio", uio_out, 8'd0);
        chk("reset oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        chk("idle uo", uo_out, 8'd0);

        // Start edge latency: acted on two edges after first sample
        @(negedge clk);
        ui_in[6] = 1'b1;
        tick(2);
        chk("start early", uo_out, 8'd0);
        tick(1);
        chk("start collect", uo_out, 8'd46);
        ui_in[6] = 1'b0;
        tick(3);

        // Full match from the round table
        for (int r = 0; r < 6; r++) begin
            sb.push_back('{rounds[r].uo, rounds[r].uio});
            play_round($sformatf("round%0d", r), rounds[r].m1, rounds[r].m2, 2'b11, rounds[r].after);
        end

        // Commits in DONE are ignored
        @(negedge clk);
        ui_in[3:0] = 4'b1000;
        ui_in[5:4] = 2'b11;
        tick(6);
        chk("done uo", uo_out, 8'd66);
        chk("done scores", uio_out, 8'h31);
        ui_in[5:4] = 2'b00;
        tick(3);
        start_pulse();
        chk("restart uo", uo_out, 8'd46);
        chk("restart scores", uio_out, 8'h00);

        // Invalid move, then valid move, then a changed repeat that must be ignored
        @(negedge clk);
        ui_in[1:0] = 2'd3;
        ui_in[4]   = 1'b1;
        tick(2);
        chk("invalid early", uo_out, 8'd46);
        tick(1);
        chk("invalid shown", uo_out, 8'd63);
        ui_in[4] = 1'b0;
        tick(3);
        commit1(2'd1);
        chk("valid clears", uo_out, 8'd46);
        commit1(2'd2);
        chk("repeat ignored", uo_out, 8'd46);
        sb.push_back('{8'd49, 8'h01});
        play_round("first move", 2'd2, 2'd0, 2'b10, 8'd46);

        // Start edge during SHOW aborts the match
        @(negedge clk);
        ui_in[3:0] = 4'b1000;
        ui_in[5:4] = 2'b11;
        tick(5);
        chk("abort show", uo_out, 8'd49);
        chk("abort show scores", uio_out, 8'h02);
        ui_in[5:4] = 2'b00;
        start_pulse();
        chk("abort uo", uo_out, 8'd46);
        chk("abort scores", uio_out, 8'h00);

        // Commit pulses while ena is low are lost
        @(negedge clk);
        ena        = 1'b0;
        ui_in[3:0] = 4'b1000;
        ui_in[5:4] = 2'b11;
        tick(4);
        ui_in[5:4] = 2'b00;
        tick(3);
        @(negedge clk);
        ena = 1'b1;
        tick(10);
        chk("ena drop uo", uo_out, 8'd46);
        chk("ena drop scores", uio_out, 8'h00);
        sb.push_back('{8'd49, 8'h01});
        play_round("after ena", 2'd1, 2'd0, 2'b11, 8'd46);

        // Asynchronous reset mid-SHOW
        @(negedge clk);
        ui_in[3:0] = 4'b0110;
        ui_in[5:4] = 2'b11;
        tick(5);
        chk("pre-reset show", uo_out, 8'd49);
        chk("pre-reset scores", uio_out, 8'h02);
        ui_in[5:4] = 2'b00;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset uo", uo_out, 8'd0);
        chk("async reset uio", uio_out, 8'd0);
        chk("async reset oe", uio_oe, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        tick(4);
        chk("post-reset idle", uo_out, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
